pipe_fetch: RTL and testbench
=============================

# pipe_fetch

Fetch stage of the pipelined Y86-64 processor, feeding the decode stage. It owns the predicted-PC register (F) and the fetch/decode pipeline register (D). It contains the byte-addressed instruction memory and a load port for the bench. Each cycle it selects the fetch PC (mispredict/return correction), splits and aligns the instruction, computes valP and the next predicted PC, and honours stall/bubble controls from pipeline control.

## Interface
Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes
- RESET_PC, 64'h0, value loaded into F_predPC on reset

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- F_stall  in  1  hold F_predPC
- D_stall  in  1  hold D register
- D_bubble  in  1  load NOP bubble into D register
- M_icode  in  4  icode in memory stage
- M_Cnd  in  1  branch condition in memory stage
- M_valA  in  64  fall-through PC of mispredicted jump
- W_icode  in  4  icode in write-back stage
- W_valM  in  64  return address popped by ret
- imem_we  in  1  instruction memory byte write enable
- imem_waddr  in  64  write byte address
- imem_wdata  in  8  write byte
- F_predPC  out  64  predicted PC register
- D_stat  out  2  status of instruction in D
- D_icode, D_ifun  out  4 each  instruction code/function
- D_rA, D_rB  out  4 each  register IDs (4'hF = none)
- D_valC  out  64  constant word
- D_valP  out  64  address of next sequential instruction

## Operation
- f_pc select, priority order:
  - M_icode==JXX(7) && !M_Cnd → M_valA.
  - W_icode==RET(9) → W_valM.
  - Otherwise → F_predPC.
- Read 10 bytes at f_pc..f_pc+9, combinationally.
- imem_error when any byte the instruction needs lies at address ≥ IMEM_BYTES. Bytes not needed are not checked.
- Byte 0 is split into icode[7:4] and ifun[3:0]. On imem_error, icode=NOP(1) and ifun=0.
- instr_valid when icode ≤ 4'hB.
- need_regids for icode ∈ {2,3,4,5,6,A,B}: rA=byte1[7:4], rB=byte1[3:0]. Otherwise rA=rB=4'hF.
- need_valC for icode ∈ {3,4,5,7,8}: valC is 8 bytes little-endian, starting at byte 1 + need_regids. Otherwise valC=0.
- valP = f_pc + 1 + need_regids + 8·need_valC, 64-bit arithmetic with wrap-around, no saturation.
- f_predPC = valC for JXX(7) or CALL(8), else valP.
- f_stat, priority order: imem_error → ADR; !instr_valid → INS; icode==HALT(0) → HLT; else AOK.
- Stat encoding: AOK=0, HLT=1, ADR=2, INS=3.
- Bubble value: stat AOK, icode NOP, ifun 0, rA=rB=F, valC=0, valP=0.
- The memory write port writes one byte per rising edge when imem_we=1. Writes at addresses ≥ IMEM_BYTES are ignored. The memory is not cleared by reset.

## Timing
- Reset (asynchronous, while reset_n=0):
  - F_predPC=RESET_PC.
  - D register holds the bubble value.
- Rising edge, F register:
  - Loads f_predPC unless F_stall=1; F_stall holds.
- Rising edge, D register, priority order:
  - D_stall=1 → hold. Stall wins if D_bubble is also 1.
  - Else D_bubble=1 → bubble.
  - Else load the fetch results.
- Latency: instruction at f_pc appears on D_* one edge later.
- A mispredict or ret correction takes effect in the same cycle the M/W inputs are presented. The corrected target appears on D_* at the next edge.
- An imem write is visible to fetch from the cycle after the write edge. A same-cycle read of that byte returns the old data.
- Reset deasserted mid-stream: the first fetch after release uses RESET_PC. Correction inputs are honoured immediately.

## Structure
- Shared package y86_pkg:
  - icode constants: HALT, NOP, RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - stat codes AOK, HLT, ADR, INS.
  - RNONE=4'hF.
  - bubble field values.
- Sub-module instr_mem: byte array, one write port, 10-byte combinational read window, per-byte out-of-range flags.
- Split/align, PC select and predPC logic stay in pipe_fetch.

## Test plan
- Reset: hold reset_n=0 across one edge → F_predPC=0, D_icode=1, D_rA=D_rB=F, D_stat=0; release → first fetch from 0.
- Load `30 F0 10 00 00 00 00 00 00 00` (irmovq $0x10,%rax) at 0, clock once → D_icode=3, D_rA=F, D_rB=0, D_valC=0x10, D_valP=0xA, F_predPC=0xA.
- Jump: `70 40 00..` (jmp 0x40) at 0 → F_predPC=0x40.
  - Then drive M_icode=7, M_Cnd=0, M_valA=0x20 with W_icode=9, W_valM=0x80 → fetch from 0x20 (mispredict beats ret).
  - With only W_icode=9 → fetch from 0x80.
- Stall/bubble: F_stall=D_stall=1 for 2 edges → F_predPC and D_* unchanged.
  - D_bubble=1 alone → D_icode=1, D_valP=0.
  - D_stall=D_bubble=1 → D holds.
- Errors: irmovq at IMEM_BYTES-4 → D_stat=ADR, D_icode=1. Byte 0xC0 → D_stat=INS. Byte 0x00 → D_stat=HLT, D_valP=f_pc+1.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: constants shared across the Y86-64 pipeline.
//   - instruction codes (icode) HALT..POPQ
//   - pipeline status codes AOK/HLT/ADR/INS
//   - register "none" ID
//   - layout of the fetch/decode pipeline register and its bubble value
//   - helpers that classify an icode by the instruction fields it carries
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] FNONE = 4'h0;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  FNONE,
        ra:    RNONE,
        rb:    RNONE,
        valc:  64'h0,
        valp:  64'h0
    };

    // Instruction carries a register-specifier byte right after byte 0.
    function automatic logic need_regids(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            default:                need_regids = 1'b0;
        endcase
    endfunction

    // Instruction carries an 8-byte constant word.
    function automatic logic need_valc(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL: need_valc = 1'b1;
            default:       need_valc = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_mem.sv
// instr_mem: byte-addressed instruction memory for the fetch stage.
//   clock   in   write clock (rising edge)
//   we      in   byte write enable
//   waddr   in   64-bit write byte address; addresses >= IMEM_BYTES are dropped
//   wdata   in   write byte
//   raddr   in   64-bit base address of the read window
//   rbytes  out  10 bytes at raddr..raddr+9, combinational (byte 0 = raddr)
//   oob     out  per-byte flag: that window byte lies at/after IMEM_BYTES
// Contents are not touched by reset.
module instr_mem #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic             clock,
    input  logic             we,
    input  logic [63:0]      waddr,
    input  logic [7:0]       wdata,
    input  logic [63:0]      raddr,
    output logic [9:0][7:0]  rbytes,
    output logic [9:0]       oob
);

    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

    logic [7:0] mem [IMEM_BYTES];

    always_ff @(posedge clock) begin
        if (we && (waddr < 64'(IMEM_BYTES))) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Out-of-range bytes read as zero so the index below is only used
    // when it is known to be inside the array.
    for (genvar i = 0; i < 10; i++) begin : g_rd
        logic [63:0] addr;
        assign addr      = raddr + 64'(i);
        assign oob[i]    = (addr >= 64'(IMEM_BYTES));
        assign rbytes[i] = oob[i] ? 8'h00 : mem[addr[AW-1:0]];
    end

endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: fetch stage of the pipelined Y86-64 processor.
// Owns the predicted-PC register (F) and the fetch/decode register (D).
//   clock       in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   F_stall     in   hold F_predPC
//   D_stall     in   hold D register (wins over D_bubble)
//   D_bubble    in   load a NOP bubble into D
//   M_icode/M_Cnd/M_valA  in  mispredicted-jump correction from memory stage
//   W_icode/W_valM        in  return-address correction from write-back stage
//   imem_we/imem_waddr/imem_wdata  in  instruction memory byte load port
//   F_predPC    out  predicted PC register
//   D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP  out  D register
module pipe_fetch
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [63:0] F_predPC,
    output logic [1:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    logic [63:0]     f_pc;
    logic [9:0][7:0] win;
    logic [9:0]      oob;

    logic [3:0]      raw_icode;
    logic [3:0]      raw_ifun;
    logic            raw_regids;
    logic            raw_valc;
    logic            valc_oob;
    logic            imem_error;

    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic            has_regids;
    logic            has_valc;
    logic            instr_valid;
    logic [63:0]     valc;
    logic [63:0]     valp;
    logic [63:0]     f_predpc;
    logic [1:0]      f_stat;
    d_reg_t          f_d;

    logic [63:0]     pred_q;
    d_reg_t          d_q;

    // A not-taken jump resolved in M beats a ret resolved in W.
    always_comb begin
        if ((M_icode == I_JXX) && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end else begin
            f_pc = pred_q;
        end
    end

    instr_mem #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_imem (
        .clock  (clock),
        .we     (imem_we),
        .waddr  (imem_waddr),
        .wdata  (imem_wdata),
        .raddr  (f_pc),
        .rbytes (win),
        .oob    (oob)
    );

    assign raw_icode  = win[0][7:4];
    assign raw_ifun   = win[0][3:0];
    assign raw_regids = need_regids(raw_icode);
    assign raw_valc   = need_valc(raw_icode);

    // Only the bytes the raw instruction actually uses may raise an
    // address error; trailing window bytes beyond its length are ignored.
    always_comb begin
        valc_oob   = raw_regids ? (|oob[9:2]) : (|oob[8:1]);
        imem_error = oob[0] | (raw_regids & oob[1]) | (raw_valc & valc_oob);
    end

    assign icode       = imem_error ? I_NOP : raw_icode;
    assign ifun        = imem_error ? FNONE : raw_ifun;
    assign has_regids  = need_regids(icode);
    assign has_valc    = need_valc(icode);
    assign instr_valid = (icode <= I_POPQ);

    // Constant word is little-endian and follows the register byte if any.
    always_comb begin
        valc = 64'h0;
        if (has_valc) begin
            for (int k = 0; k < 8; k++) begin
                valc[8*k +: 8] = has_regids ? win[k+2] : win[k+1];
            end
        end
    end

    assign valp = f_pc + 64'd1
                + (has_regids ? 64'd1 : 64'd0)
                + (has_valc   ? 64'd8 : 64'd0);

    assign f_predpc = ((icode == I_JXX) || (icode == I_CALL)) ? valc : valp;

    always_comb begin
        if (imem_error) begin
            f_stat = STAT_ADR;
        end else if (!instr_valid) begin
            f_stat = STAT_INS;
        end else if (icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end
    end

    always_comb begin
        f_d       = D_BUBBLE;
        f_d.stat  = f_stat;
        f_d.icode = icode;
        f_d.ifun  = ifun;
        f_d.ra    = has_regids ? win[1][7:4] : RNONE;
        f_d.rb    = has_regids ? win[1][3:0] : RNONE;
        f_d.valc  = valc;
        f_d.valp  = valp;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pred_q <= RESET_PC;
        end else if (!F_stall) begin
            pred_q <= f_predpc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= D_BUBBLE;
        end else if (D_stall) begin
            d_q <= d_q;
        end else if (D_bubble) begin
            d_q <= D_BUBBLE;
        end else begin
            d_q <= f_d;
        end
    end

    assign F_predPC = pred_q;
    assign D_stat   = d_q.stat;
    assign D_icode  = d_q.icode;
    assign D_ifun   = d_q.ifun;
    assign D_rA     = d_q.ra;
    assign D_rB     = d_q.rb;
    assign D_valC   = d_q.valc;
    assign D_valP   = d_q.valp;

endmodule

// File: tb/tb_pipe_fetch.sv
module tb_pipe_fetch;

    localparam int          IMEM = 1024;
    localparam logic [63:0] RPC  = 64'h0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [63:0] F_predPC;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    always #5 clock = ~clock;

    pipe_fetch #(.IMEM_BYTES(IMEM), .RESET_PC(RPC)) dut (
        .clock(clock), .reset_n(reset_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
    );

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pred;
    } exp_t;

    typedef logic [7:0] prog_t [10];

    exp_t       exp_q[$];
    exp_t       m;
    logic [7:0] m_mem [IMEM];
    int         total = 0;
    int         bad   = 0;

    function automatic exp_t bubble(input logic [63:0] pred);
        exp_t b;
        b = '{stat: 2'd0, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
              valc: 64'h0, valp: 64'h0, pred: pred};
        return b;
    endfunction

    // Encoded length in bytes for each icode; unknown codes occupy one byte.
    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 1;
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [63:0] a);
        if (a < 64'(IMEM)) return m_mem[a[9:0]];
        return 8'h00;
    endfunction

    // Fetch result at pc; the pred field carries the next predicted PC.
    function automatic exp_t fetch(input logic [63:0] pc);
        exp_t       r;
        logic [7:0] b0, b1;
        int         len;
        logic       err;
        b0      = rd(pc);
        r.icode = b0[7:4];
        r.ifun  = b0[3:0];
        len     = ilen(r.icode);
        err     = ({1'b0, pc} + 65'(len)) > 65'(IMEM);
        if (err) begin
            r.icode = 4'h1;
            r.ifun  = 4'h0;
            len     = 1;
        end
        b1   = rd(pc + 64'd1);
        r.ra = (len == 2 || len == 10) ? b1[7:4] : 4'hF;
        r.rb = (len == 2 || len == 10) ? b1[3:0] : 4'hF;
        r.valc = 64'h0;
        if (len >= 9) begin
            for (int k = 0; k < 8; k++) r.valc[8*k +: 8] = rd(pc + 64'(len - 8 + k));
        end
        r.valp = pc + 64'(len);
        if (err)                 r.stat = 2'd2;
        else if (r.icode > 4'hB) r.stat = 2'd3;
        else if (r.icode == 4'h0) r.stat = 2'd1;
        else                     r.stat = 2'd0;
        r.pred = (r.icode == 4'h7 || r.icode == 4'h8) ? r.valc : r.valp;
        return r;
    endfunction

    // Advance the reference model by one edge using the inputs now applied,
    // queue the expected post-edge state, then move past the edge.
    task automatic step();
        exp_t        f;
        logic [63:0] pc, npred;
        if (!reset_n) begin
            m = bubble(RPC);
        end else begin
            if (M_icode == 4'h7 && !M_Cnd) pc = M_valA;
            else if (W_icode == 4'h9)      pc = W_valM;
            else                           pc = m.pred;
            f     = fetch(pc);
            npred = F_stall ? m.pred : f.pred;
            if (!D_stall) m = D_bubble ? bubble(64'h0) : f;
            m.pred = npred;
        end
        if (imem_we && imem_waddr < 64'(IMEM)) m_mem[imem_waddr[9:0]] = imem_wdata;
        exp_q.push_back(m);
        @(posedge clock);
        #2;
    endtask

    task automatic load(input logic [63:0] base, input prog_t p);
        for (int i = 0; i < 10; i++) begin
            imem_we = 1'b1; imem_waddr = base + 64'(i); imem_wdata = p[i];
            step();
        end
        imem_we = 1'b0;
    endtask

    task automatic wr1(input logic [63:0] a, input logic [7:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        step();
        imem_we = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic clear_ctl();
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_icode = 4'h0; M_Cnd = 0; M_valA = 64'h0;
        W_icode = 4'h0; W_valM = 64'h0;
        imem_we = 0; imem_waddr = 64'h0; imem_wdata = 8'h0;
    endtask

    // Scoreboard monitor: one expected entry per edge that the driver modelled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !==
                    {e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp}) begin
                    bad++;
                    $display("FAIL d_reg t=%0t got stat=%0d ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h want stat=%0d ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h",
                             $time, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
                             e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp);
                end
                total++;
                if (F_predPC !== e.pred) begin
                    bad++;
                    $display("FAIL predpc t=%0t got=%h want=%h", $time, F_predPC, e.pred);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        prog_t p;
        reset_n = 1'b0;
        clear_ctl();
        m = bubble(RPC);
        @(negedge clock);

        // Fill memory with NOPs while held in reset.
        for (int a = 0; a < IMEM; a++) wr1(64'(a), 8'h10);
        step();
        chk("rst_predpc", F_predPC, 64'h0);
        chk("rst_icode", 64'(D_icode), 64'h1);
        chk("rst_ra", 64'(D_rA), 64'hF);
        chk("rst_rb", 64'(D_rB), 64'hF);
        chk("rst_stat", 64'(D_stat), 64'h0);
        reset_n = 1'b1;
        step();
        chk("rel_valp", D_valP, 64'h1);

        // irmovq $0x10,%rax at 0
        reset_n = 1'b0;
        p = '{8'h30, 8'hF0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'h0, p);
        reset_n = 1'b1;
        step();
        chk("irm_icode", 64'(D_icode), 64'h3);
        chk("irm_ra", 64'(D_rA), 64'hF);
        chk("irm_rb", 64'(D_rB), 64'h0);
        chk("irm_valc", D_valC, 64'h10);
        chk("irm_valp", D_valP, 64'hA);
        chk("irm_pred", F_predPC, 64'hA);

        // jmp 0x40 at 0, then mispredict beats ret, then ret alone
        reset_n = 1'b0;
        p = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        load(64'h0, p);
        reset_n = 1'b1;
        step();
        chk("jmp_pred", F_predPC, 64'h40);
        chk("jmp_valc", D_valC, 64'h40);
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h20;
        W_icode = 4'h9; W_valM = 64'h80;
        step();
        chk("mispred_valp", D_valP, 64'h21);
        M_icode = 4'h0;
        step();
        chk("ret_valp", D_valP, 64'h81);
        W_icode = 4'h0;

        // Stall and bubble
        F_stall = 1; D_stall = 1;
        step();
        step();
        chk("stall_pred", F_predPC, 64'h81);
        chk("stall_valp", D_valP, 64'h81);
        F_stall = 0; D_stall = 0; D_bubble = 1;
        step();
        chk("bub_icode", 64'(D_icode), 64'h1);
        chk("bub_valp", D_valP, 64'h0);
        D_bubble = 0;
        step();
        D_stall = 1; D_bubble = 1;
        step();
        chk("stallbub_valp", D_valP, 64'h83);
        chk("stallbub_pred", F_predPC, 64'h84);
        D_stall = 0; D_bubble = 0;

        // Address error, invalid instruction, halt; correction right at release
        reset_n = 1'b0;
        p = '{8'h30, 8'hF0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'(IMEM - 4), p);
        wr1(64'h100, 8'hC0);
        wr1(64'h200, 8'h00);
        reset_n = 1'b1;
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'(IMEM - 4);
        step();
        chk("adr_stat", 64'(D_stat), 64'h2);
        chk("adr_icode", 64'(D_icode), 64'h1);
        chk("adr_valp", D_valP, 64'(IMEM - 3));
        M_icode = 4'h0; W_icode = 4'h9; W_valM = 64'h100;
        step();
        chk("ins_stat", 64'(D_stat), 64'h3);
        chk("ins_icode", 64'(D_icode), 64'hC);
        W_valM = 64'h200;
        step();
        chk("hlt_stat", 64'(D_stat), 64'h1);
        chk("hlt_valp", D_valP, 64'h201);
        clear_ctl();

        // Randomise memory under reset, then random traffic
        reset_n = 1'b0;
        for (int a = 0; a < IMEM; a++) wr1(64'(a), 8'($urandom));
        reset_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            reset_n  = ($urandom_range(0, 149) != 0);
            F_stall  = ($urandom_range(0, 7) == 0);
            D_stall  = ($urandom_range(0, 7) == 0);
            D_bubble = ($urandom_range(0, 7) == 0);
            M_icode  = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom);
            M_Cnd    = 1'($urandom);
            M_valA   = ($urandom_range(0, 15) == 0) ? {$urandom(), $urandom()}
                                                     : 64'($urandom_range(0, IMEM + 15));
            W_icode  = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom);
            W_valM   = 64'($urandom_range(0, IMEM + 15));
            imem_we    = 1'($urandom);
            imem_waddr = 64'($urandom_range(0, IMEM + 7));
            imem_wdata = 8'($urandom);
            step();
        end
        clear_ctl();
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
